// File: rtl/a_buf_loader.sv
// a_buf_loader: loads tile rows from memory into the free half of the ping-pong A buffer and hands full halves to the array
module a_buf_loader #(
  parameter int TMMA_CNT_WIDTH = 6,
  parameter int SARRAY_LOAD_WIDTH = 256,
  parameter int ADDR_WIDTH = 32,
  parameter int MAX_OUT = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         cmd_valid_i,
  output logic                         cmd_ready_o,
  input  logic [ADDR_WIDTH-1:0]        cmd_base_addr_i,
  input  logic [ADDR_WIDTH-1:0]        cmd_stride_i,
  input  logic [TMMA_CNT_WIDTH:0]      cmd_rows_i,
  output logic                         mem_req_valid_o,
  input  logic                         mem_req_ready_i,
  output logic [ADDR_WIDTH-1:0]        mem_req_addr_o,
  input  logic                         mem_resp_valid_i,
  input  logic [SARRAY_LOAD_WIDTH-1:0] mem_resp_data_i,
  output logic                         wr_a_buf_valid_o,
  output logic                         wr_a_buf_id_o,
  output logic [TMMA_CNT_WIDTH-1:0]    wr_a_buf_addr_o,
  output logic [SARRAY_LOAD_WIDTH-1:0] wr_a_buf_data_o,
  output logic                         tile_done_o,
  output logic                         tile_done_id_o,
  output logic [1:0]                   buf_full_o,
  input  logic                         buf_release_i,
  input  logic                         buf_release_id_i
);
  localparam int CW = TMMA_CNT_WIDTH + 1;
  localparam int OW = $clog2(MAX_OUT + 1);
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;
  state_t state_q, state_d;
  logic live_q, fill_id_q, fill_id_d, wr_valid_q, wr_valid_d, wr_id_q, wr_id_d, done_q, done_d;
  logic [1:0] buf_full_q, buf_full_d;
  logic [CW-1:0] rows_q, rows_d, issued_q, issued_d, recv_q, recv_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d, stride_q, stride_d;
  logic [OW-1:0] out_q, out_d;
  logic [TMMA_CNT_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [SARRAY_LOAD_WIDTH-1:0] wr_data_q, wr_data_d;
  logic cmd_fire, req_fire, resp_ok;
  always_comb begin
    cmd_ready_o = live_q && state_q == IDLE && !buf_full_q[fill_id_q];
    mem_req_valid_o = state_q == ISSUE && issued_q != rows_q && out_q < OW'(MAX_OUT);
    mem_req_addr_o = addr_q;
    cmd_fire = cmd_valid_i && cmd_ready_o;
    req_fire = mem_req_valid_o && mem_req_ready_i;
    resp_ok = mem_resp_valid_i && state_q != IDLE && recv_q != rows_q;
    state_d = state_q;
    fill_id_d = fill_id_q;
    rows_d = rows_q;
    stride_d = stride_q;
    addr_d = req_fire ? addr_q + stride_q : addr_q;
    issued_d = issued_q + CW'(req_fire);
    recv_d = recv_q + CW'(resp_ok);
    out_d = out_q + OW'(req_fire) - OW'(resp_ok && out_q != '0);
    wr_valid_d = resp_ok;
    wr_id_d = fill_id_q;
    wr_addr_d = resp_ok ? recv_q[TMMA_CNT_WIDTH-1:0] : wr_addr_q;
    wr_data_d = resp_ok ? mem_resp_data_i : wr_data_q;
    done_d = resp_ok && recv_q + CW'(1) == rows_q;
    buf_full_d = buf_full_q;
    if (buf_release_i) buf_full_d[buf_release_id_i] = 1'b0;
    if (state_q == ISSUE && req_fire && issued_d == rows_q) state_d = DRAIN;
    if (done_q) begin
      state_d = IDLE;
      fill_id_d = ~fill_id_q;
      buf_full_d[fill_id_q] = 1'b1;
    end
    if (cmd_fire && cmd_rows_i != '0) begin
      state_d = ISSUE;
      rows_d = cmd_rows_i;
      stride_d = cmd_stride_i;
      addr_d = cmd_base_addr_i;
      issued_d = '0;
      recv_d = '0;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      live_q <= 1'b0;
      fill_id_q <= 1'b0;
      buf_full_q <= '0;
      rows_q <= '0;
      issued_q <= '0;
      recv_q <= '0;
      addr_q <= '0;
      stride_q <= '0;
      out_q <= '0;
      wr_valid_q <= 1'b0;
      wr_id_q <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      live_q <= 1'b1;
      fill_id_q <= fill_id_d;
      buf_full_q <= buf_full_d;
      rows_q <= rows_d;
      issued_q <= issued_d;
      recv_q <= recv_d;
      addr_q <= addr_d;
      stride_q <= stride_d;
      out_q <= out_d;
      wr_valid_q <= wr_valid_d;
      wr_id_q <= wr_id_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      done_q <= done_d;
    end
  end
  assign wr_a_buf_valid_o = wr_valid_q;
  assign wr_a_buf_id_o = wr_id_q;
  assign wr_a_buf_addr_o = wr_addr_q;
  assign wr_a_buf_data_o = wr_data_q;
  assign tile_done_o = done_q;
  assign tile_done_id_o = wr_id_q;
  assign buf_full_o = buf_full_q;
endmodule

// File: tb/tb_a_buf_loader.sv
// tb_a_buf_loader: directed self-checking bench for a_buf_loader with an in-order memory model
module tb_a_buf_loader;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cmd_valid_i = 1'b0;
  logic cmd_ready_o;
  logic [31:0] cmd_base_addr_i = '0;
  logic [31:0] cmd_stride_i = '0;
  logic [6:0] cmd_rows_i = '0;
  logic mem_req_valid_o;
  logic mem_req_ready_i = 1'b1;
  logic [31:0] mem_req_addr_o;
  logic mem_resp_valid_i = 1'b0;
  logic [255:0] mem_resp_data_i = '0;
  logic wr_a_buf_valid_o;
  logic wr_a_buf_id_o;
  logic [5:0] wr_a_buf_addr_o;
  logic [255:0] wr_a_buf_data_o;
  logic tile_done_o;
  logic tile_done_id_o;
  logic [1:0] buf_full_o;
  logic buf_release_i = 1'b0;
  logic buf_release_id_i = 1'b0;
  always #5 clk = ~clk;
  a_buf_loader dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
    .cmd_base_addr_i(cmd_base_addr_i), .cmd_stride_i(cmd_stride_i), .cmd_rows_i(cmd_rows_i),
    .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i), .mem_req_addr_o(mem_req_addr_o),
    .mem_resp_valid_i(mem_resp_valid_i), .mem_resp_data_i(mem_resp_data_i),
    .wr_a_buf_valid_o(wr_a_buf_valid_o), .wr_a_buf_id_o(wr_a_buf_id_o),
    .wr_a_buf_addr_o(wr_a_buf_addr_o), .wr_a_buf_data_o(wr_a_buf_data_o),
    .tile_done_o(tile_done_o), .tile_done_id_o(tile_done_id_o), .buf_full_o(buf_full_o),
    .buf_release_i(buf_release_i), .buf_release_id_i(buf_release_id_i)
  );
  typedef struct {logic [31:0] a; int due;} mreq_t;
  typedef struct {logic id; logic [5:0] a; logic [255:0] d; logic done; logic did; int c;} wr_t;
  mreq_t mq[$];
  logic [31:0] req_log[$];
  int req_cyc[$];
  int resp_cyc[$];
  wr_t wlog[$];
  int checks = 0, failures = 0, cyc = 0, outc = 0, outmax = 0, stalls = 0, unstable = 0, done_cnt = 0;
  int lat = 2;
  bit hold = 0, toggle = 0, pv = 0;
  logic [31:0] pa = '0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (!rst_n) begin
      mq.delete();
      mem_resp_valid_i = 1'b0;
      outc = 0;
      pv = 0;
    end else begin
      if (wr_a_buf_valid_o) wlog.push_back('{wr_a_buf_id_o, wr_a_buf_addr_o, wr_a_buf_data_o, tile_done_o, tile_done_id_o, cyc});
      if (tile_done_o) done_cnt++;
      if (pv && (!mem_req_valid_o || mem_req_addr_o !== pa)) unstable++;
      mem_req_ready_i = toggle ? cyc[0] : 1'b1;
      mem_resp_valid_i = 1'b0;
      if (!hold && mq.size() > 0 && mq[0].due <= cyc) begin
        mem_resp_valid_i = 1'b1;
        mem_resp_data_i = {8{mq[0].a}};
        void'(mq.pop_front());
        resp_cyc.push_back(cyc);
        outc--;
      end
      pv = mem_req_valid_o && !mem_req_ready_i;
      pa = mem_req_addr_o;
      if (pv) stalls++;
      if (mem_req_valid_o && mem_req_ready_i) begin
        mq.push_back('{mem_req_addr_o, cyc + lat});
        req_log.push_back(mem_req_addr_o);
        req_cyc.push_back(cyc);
        outc++;
        if (outc > outmax) outmax = outc;
      end
    end
  end
  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic rst_outputs(input string t);
    chk({t, "_cmd_ready"}, cmd_ready_o, 0);
    chk({t, "_req_valid"}, mem_req_valid_o, 0);
    chk({t, "_req_addr"}, mem_req_addr_o, 0);
    chk({t, "_wr_valid"}, wr_a_buf_valid_o, 0);
    chk({t, "_wr_id"}, wr_a_buf_id_o, 0);
    chk({t, "_wr_addr"}, wr_a_buf_addr_o, 0);
    chk({t, "_wr_data"}, wr_a_buf_data_o, 0);
    chk({t, "_done"}, tile_done_o, 0);
    chk({t, "_done_id"}, tile_done_id_o, 0);
    chk({t, "_buf_full"}, buf_full_o, 0);
  endtask
  task automatic wait_accept();
    bit acc = 0;
    for (int k = 0; k < 300 && !acc; k++) begin
      @(negedge clk);
      acc = cmd_ready_o;
    end
    if (!acc) chk("cmd_accept", cmd_ready_o, 1);
    @(posedge clk); #1;
    cmd_valid_i = 1'b0;
  endtask
  task automatic send_cmd(input logic [31:0] b, input logic [31:0] s, input logic [6:0] r);
    @(posedge clk); #1;
    cmd_valid_i = 1'b1;
    cmd_base_addr_i = b;
    cmd_stride_i = s;
    cmd_rows_i = r;
    wait_accept();
  endtask
  task automatic pulse_release(input logic id);
    @(posedge clk); #1;
    buf_release_i = 1'b1;
    buf_release_id_i = id;
    @(posedge clk); #1;
    buf_release_i = 1'b0;
  endtask
  task automatic wait_done(input bit rel0);
    bit seen = 0;
    for (int k = 0; k < 400 && !seen; k++) begin
      @(negedge clk);
      if (tile_done_o) begin
        seen = 1;
        if (rel0) begin
          buf_release_i = 1'b1;
          buf_release_id_i = 1'b0;
        end
      end
    end
    chk("tile_done_seen", tile_done_o, 1);
    @(posedge clk); #1;
    buf_release_i = 1'b0;
  endtask
  task automatic check_reqs(input string t, input int n0, input int n, input logic [31:0] b, input logic [31:0] s);
    int bad = 0;
    logic [31:0] e;
    for (int i = 0; i < n; i++) begin
      e = b + s * 32'(i);
      if (n0 + i >= req_log.size()) bad++;
      else if (req_log[n0 + i] !== e) bad++;
    end
    chk({t, "_addr_errs"}, bad, 0);
  endtask
  task automatic check_writes(input string t, input int w0, input int n, input logic id, input logic [31:0] b, input logic [31:0] s);
    int bad = 0;
    logic [31:0] e;
    for (int i = 0; i < n; i++) begin
      e = b + s * 32'(i);
      if (w0 + i >= wlog.size()) bad++;
      else if (wlog[w0 + i].id !== id || wlog[w0 + i].a !== 6'(i) || wlog[w0 + i].d !== {8{e}} ||
               wlog[w0 + i].done !== (i == n - 1) || (wlog[w0 + i].done && wlog[w0 + i].did !== id)) bad++;
    end
    chk({t, "_write_errs"}, bad, 0);
  endtask
  initial begin
    int n0, w0, d0, r0, w1, rdy;
    repeat (2) @(negedge clk);
    rst_outputs("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    n0 = req_log.size(); w0 = wlog.size(); d0 = done_cnt; r0 = resp_cyc.size();
    send_cmd(32'h1000, 32'h20, 7'd4);
    @(negedge clk);
    chk("cmd_to_req_valid", mem_req_valid_o, 1);
    chk("cmd_to_req_addr", mem_req_addr_o, 32'h1000);
    wait_done(0);
    @(negedge clk);
    chk("basic_buf_full", buf_full_o, 2'b01);
    chk("basic_ready_again", cmd_ready_o, 1);
    chk("basic_req_count", req_log.size() - n0, 4);
    check_reqs("basic_req", n0, 4, 32'h1000, 32'h20);
    chk("basic_one_per_cycle", (req_cyc.size() >= n0 + 4) ? req_cyc[n0 + 3] - req_cyc[n0] : -1, 3);
    chk("basic_wr_count", wlog.size() - w0, 4);
    check_writes("basic_wr", w0, 4, 1'b0, 32'h1000, 32'h20);
    chk("basic_resp_to_write", (wlog.size() >= w0 + 4 && resp_cyc.size() >= r0 + 4) ? wlog[w0 + 3].c - resp_cyc[r0 + 3] : -1, 1);
    chk("basic_done_count", done_cnt - d0, 1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("pp_reset_full", buf_full_o, 2'b00);
    @(posedge clk); #1;
    rst_n = 1'b1;
    w0 = wlog.size();
    send_cmd(32'h2000, 32'h100, 7'd64);
    wait_done(0);
    send_cmd(32'h8000, 32'h100, 7'd64);
    wait_done(0);
    @(negedge clk);
    chk("pp_full_both", buf_full_o, 2'b11);
    chk("pp_wr_count", wlog.size() - w0, 128);
    check_writes("pp_a", w0, 64, 1'b0, 32'h2000, 32'h100);
    check_writes("pp_b", w0 + 64, 64, 1'b1, 32'h8000, 32'h100);
    @(posedge clk); #1;
    cmd_valid_i = 1'b1;
    cmd_base_addr_i = 32'h3000;
    cmd_stride_i = 32'h4;
    cmd_rows_i = 7'd2;
    n0 = req_log.size();
    rdy = 0;
    repeat (20) begin
      @(negedge clk);
      rdy += int'(cmd_ready_o);
    end
    chk("pp_blocked_ready", rdy, 0);
    chk("pp_blocked_no_req", req_log.size() - n0, 0);
    pulse_release(1'b0);
    w1 = wlog.size();
    wait_accept();
    wait_done(0);
    chk("pp_third_count", wlog.size() - w1, 2);
    check_writes("pp_third", w1, 2, 1'b0, 32'h3000, 32'h4);
    @(negedge clk);
    chk("pp_third_full", buf_full_o, 2'b11);
    pulse_release(1'b1);
    @(negedge clk);
    chk("rel1_full", buf_full_o, 2'b01);
    hold = 1;
    outmax = 0;
    n0 = req_log.size(); w0 = wlog.size();
    send_cmd(32'h4000, 32'h40, 7'd8);
    repeat (10) @(negedge clk);
    chk("lim_req_count", req_log.size() - n0, 4);
    chk("lim_valid_low", mem_req_valid_o, 0);
    @(posedge clk); #1;
    hold = 0;
    wait_done(1);
    @(negedge clk);
    chk("rel_and_done_full", buf_full_o, 2'b10);
    chk("lim_outmax", outmax, 4);
    chk("lim_total_reqs", req_log.size() - n0, 8);
    check_reqs("lim_req", n0, 8, 32'h4000, 32'h40);
    check_writes("lim_wr", w0, 8, 1'b1, 32'h4000, 32'h40);
    pulse_release(1'b1);
    toggle = 1;
    stalls = 0;
    unstable = 0;
    n0 = req_log.size(); w0 = wlog.size();
    send_cmd(32'hFFFF_FFF0, 32'h10, 7'd3);
    wait_done(0);
    toggle = 0;
    chk("bp_req_count", req_log.size() - n0, 3);
    check_reqs("bp_req", n0, 3, 32'hFFFF_FFF0, 32'h10);
    chk("bp_stalled", stalls > 0, 1);
    chk("bp_addr_stable", unstable, 0);
    check_writes("bp_wr", w0, 3, 1'b0, 32'hFFFF_FFF0, 32'h10);
    @(negedge clk);
    chk("bp_full", buf_full_o, 2'b01);
    pulse_release(1'b0);
    @(negedge clk);
    chk("zero_pre_full", buf_full_o, 2'b00);
    n0 = req_log.size(); w0 = wlog.size(); d0 = done_cnt;
    send_cmd(32'hABC0, 32'h10, 7'd0);
    repeat (5) @(negedge clk);
    chk("zero_no_req", req_log.size() - n0, 0);
    chk("zero_no_write", wlog.size() - w0, 0);
    chk("zero_no_done", done_cnt - d0, 0);
    chk("zero_ready", cmd_ready_o, 1);
    send_cmd(32'h7700, 32'h8, 7'd1);
    wait_done(0);
    chk("one_req_count", req_log.size() - n0, 1);
    chk("one_wr_count", wlog.size() - w0, 1);
    check_writes("one_wr", w0, 1, 1'b1, 32'h7700, 32'h8);
    @(negedge clk);
    chk("one_full", buf_full_o, 2'b10);
    pulse_release(1'b0);
    @(negedge clk);
    chk("rel_not_full_ignored", buf_full_o, 2'b10);
    w0 = wlog.size();
    send_cmd(32'h9000, 32'h20, 7'd8);
    for (int k = 0; k < 100 && wlog.size() - w0 < 2; k++) @(negedge clk);
    chk("mid_two_written", wlog.size() - w0 >= 2, 1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    rst_outputs("midreset");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    w0 = wlog.size();
    send_cmd(32'h5000, 32'h20, 7'd2);
    wait_done(0);
    chk("post_reset_wr_count", wlog.size() - w0, 2);
    check_writes("post_reset_wr", w0, 2, 1'b0, 32'h5000, 32'h20);
    @(negedge clk);
    chk("post_reset_full", buf_full_o, 2'b01);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
